muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle RV32M execution unit. The EX stage issues MUL/DIV-class operations here instead of computing them in one cycle, then stalls until DONE.
- Uses the same 5-bit ALU SELECT encoding and the same DATA1/DATA2 operand convention as the single-cycle ALU.
- Returns a 32-bit RESULT to the EX/MEM pipeline register.
- Iterative: one shift-add (multiply) or one restoring-subtract (divide) step per clock.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITER, 32, iteration count; must equal XLEN.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  issue request; sampled only in IDLE.
SELECT  input  5  operation code: 01000 MUL, 01001 MULH, 01010 MULHU, 01011 MULHSU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
DATA1  input  32  rs1 operand (multiplicand / dividend).
DATA2  input  32  rs2 operand (multiplier / divisor).
FLUSH  input  1  abort from branch mispredict or trap.
BUSY  output  1  operation in progress (state != IDLE).
DONE  output  1  one-cycle pulse; RESULT valid.
RESULT  output  32  operation result; held until the next accepted START.

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high (RESET).
- Reset: state=IDLE, BUSY=0, DONE=0, RESULT=0, all internal registers cleared. RESET wins over START and FLUSH.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - START=1 with SELECT in 01000..01111 latches SELECT, the operand magnitudes and the sign flags.
  - If SELECT is not an M-op, START is ignored: no state change, DONE stays 0.
  - Signedness: DATA1 is signed for MULH/MULHSU/DIV/REM; DATA2 is signed for MULH/DIV/REM. A negative signed operand is replaced by its two's-complement magnitude.
- MUL:
  - 32 cycles of shift-add on a 64-bit accumulator.
  - The 64-bit product is negated in FIN if sign1^sign2.
  - MUL returns bits [31:0]; MULH/MULHU/MULHSU return bits [63:32].
- DIV:
  - 32 cycles of restoring division on a 33-bit partial remainder.
  - Quotient is negated if sign1^sign2 (DIV only).
  - Remainder takes the sign of the dividend (REM only).
- Fast path (IDLE goes directly to FIN; DONE at cycle 2):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give DATA1.
  - Signed overflow (DIV/REM with DATA1=0x80000000 and DATA2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Latency, with START sampled at cycle 0:
  - Cycles 1..32: iterate.
  - Cycle 33: FIN; RESULT is updated at the end of FIN.
  - Cycle 34: DONE=1 for exactly 1 cycle; state is back in IDLE.
  - DONE is registered: it rises on the edge that leaves FIN. BUSY is 1 for cycles 1..33.
- START while BUSY: ignored. The EX stage must hold the instruction stalled.
- Back-to-back: START may be asserted in the same cycle DONE=1. It is accepted because state is IDLE.
- FLUSH while BUSY: state goes to IDLE on the next edge, no DONE, RESULT unchanged.
- FLUSH in IDLE: START is suppressed that cycle.
- RESET mid-operation: same as the reset values above. No DONE is produced.
- Operand changes on DATA1/DATA2/SELECT after acceptance have no effect.

Decomposition:
- Shared package `rv32_alu_pkg`:
  - ALU_SEL_* localparams for all 5-bit SELECT codes (shared with the ALU and the control unit).
  - MDU state encoding.
  - XLEN.
- One natural sub-module, `mdu_divider_core`: restoring divide datapath (partial remainder, quotient shift, count).
- The multiplier datapath stays inline in `muldiv_unit`.

Test Plan:
- Reset: RESET for 2 cycles mid-DIV -> BUSY=0, DONE=0, RESULT=0; no DONE pulse follows.
- MUL: DATA1=7, DATA2=-3 -> RESULT=0xFFFFFFEB, DONE at cycle 34, BUSY high cycles 1..33.
- MULH/MULHU/MULHSU: DATA1=0xFFFFFFFF, DATA2=0xFFFFFFFF -> MULH=0x00000000, MULHU=0xFFFFFFFE, MULHSU=0xFFFFFFFF.
- DIV/REM signs: DATA1=-7, DATA2=2 -> DIV=0xFFFFFFFD (-3), REM=0xFFFFFFFF (-1); DIVU/REMU with DATA1=7, DATA2=2 -> 3 and 1.
- Specials: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000, REM -> 0; each with DONE at cycle 2.
- Control:
  - START while BUSY is ignored.
  - FLUSH at cycle 10 -> IDLE at cycle 11, no DONE, RESULT keeps the prior value.
  - START in the DONE cycle is accepted.
  - SELECT=00000 with START -> no BUSY.

Source files
------------

// File: rtl/rv32_alu_pkg.sv
// Shared RV32 ALU definitions: SELECT codes, datapath width and the MDU state encoding.
// Pure declarations; no timing or flow control of its own.
package rv32_alu_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_SEL_MUL    = 5'b01000;
    localparam logic [4:0] ALU_SEL_MULH   = 5'b01001;
    localparam logic [4:0] ALU_SEL_MULHU  = 5'b01010;
    localparam logic [4:0] ALU_SEL_MULHSU = 5'b01011;
    localparam logic [4:0] ALU_SEL_DIV    = 5'b01100;
    localparam logic [4:0] ALU_SEL_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_SEL_REM    = 5'b01110;
    localparam logic [4:0] ALU_SEL_REMU   = 5'b01111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_FIN  = 2'd3
    } mdu_state_e;

    function automatic logic is_mop(input logic [4:0] sel);
        return sel[4:3] == 2'b01;
    endfunction

endpackage

// File: rtl/mdu_divider_core.sv
// Unsigned restoring divider on operand magnitudes, one quotient bit per clock.
// ITER cycles after load_i; last_o marks the final step; abort_i stops it, no backpressure.
module mdu_divider_core #(
    parameter int XLEN = rv32_alu_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            last_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);
    localparam int CW = $clog2(ITER + 1);

    logic [XLEN-1:0] rem_q, quo_q, divisor_q;
    logic [CW-1:0]   cnt_q;
    logic            active_q;

    // 33-bit partial remainder: previous remainder shifted left with the next dividend bit
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;
    logic            borrow;

    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = {1'b0, shifted} - {2'b00, divisor_q};
    assign borrow  = diff[XLEN+1];
    assign last_o  = active_q && (cnt_q == CW'(ITER - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            active_q  <= 1'b0;
        end else if (load_i) begin
            rem_q     <= '0;
            quo_q     <= dividend_i;
            divisor_q <= divisor_i;
            cnt_q     <= '0;
            active_q  <= 1'b1;
        end else if (abort_i) begin
            active_q  <= 1'b0;
        end else if (active_q) begin
            rem_q     <= borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            quo_q     <= {quo_q[XLEN-2:0], ~borrow};
            cnt_q     <= cnt_q + CW'(1);
            if (last_o) begin
                active_q <= 1'b0;
            end
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit; DONE 34 cycles after START (2 on divide special cases).
// No queueing: START is only taken in IDLE, the EX stage stalls while BUSY; FLUSH aborts.
module muldiv_unit #(
    parameter int XLEN = rv32_alu_pkg::XLEN,
    parameter int ITER = XLEN
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);
    import rv32_alu_pkg::*;

    localparam int CW = $clog2(ITER + 1);

    mdu_state_e        state_q, state_d;
    logic [2:0]        op_q;
    logic              sign1_q, sign2_q, dz_q, ovf_q, done_q;
    logic [XLEN-1:0]   mag1_q, result_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    logic              accept, is_div, signed1, signed2, s1, s2, dz, ovf;
    logic [XLEN-1:0]   m1, m2, quo, rem, fin_res;
    logic              div_last;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_next, prod;

    assign is_div  = SELECT[2];
    assign signed1 = (SELECT[2:0] == 3'b001) || (SELECT[2:0] == 3'b011) ||
                     (SELECT[2:0] == 3'b100) || (SELECT[2:0] == 3'b110);
    assign signed2 = (SELECT[2:0] == 3'b001) || (SELECT[2:0] == 3'b100) ||
                     (SELECT[2:0] == 3'b110);
    assign s1      = signed1 && DATA1[XLEN-1];
    assign s2      = signed2 && DATA2[XLEN-1];
    assign m1      = s1 ? -DATA1 : DATA1;
    assign m2      = s2 ? -DATA2 : DATA2;
    assign dz      = is_div && (DATA2 == '0);
    assign ovf     = is_div && !SELECT[0] && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (&DATA2);
    assign accept  = (state_q == MDU_IDLE) && START && !FLUSH && is_mop(SELECT);

    mdu_divider_core #(.XLEN(XLEN), .ITER(ITER)) u_div (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .load_i      (accept && is_div && !dz && !ovf),
        .abort_i     (FLUSH),
        .dividend_i  (m1),
        .divisor_i   (m2),
        .last_o      (div_last),
        .quotient_o  (quo),
        .remainder_o (rem)
    );

    // Shift-add: multiplier sits in the low half and drains out as the product fills in
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag1_q} : '0);
    assign acc_next = {mul_sum, acc_q[XLEN-1:1]};
    assign prod     = (sign1_q ^ sign2_q) ? -acc_q : acc_q;

    always_comb begin
        fin_res = '0;
        if (!op_q[2]) begin
            fin_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else if (dz_q) begin
            fin_res = op_q[1] ? (sign1_q ? -mag1_q : mag1_q) : '1;
        end else if (ovf_q) begin
            fin_res = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end else if (op_q[1]) begin
            fin_res = sign1_q ? -rem : rem;
        end else begin
            fin_res = (sign1_q ^ sign2_q) ? -quo : quo;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_IDLE: if (accept) state_d = !is_div ? MDU_MUL : ((dz || ovf) ? MDU_FIN : MDU_DIV);
            MDU_MUL:  if (cnt_q == CW'(ITER - 1)) state_d = MDU_FIN;
            MDU_DIV:  if (div_last) state_d = MDU_FIN;
            MDU_FIN:  state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
        if (FLUSH && state_q != MDU_IDLE) begin
            state_d = MDU_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= MDU_IDLE;
            op_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            mag1_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == MDU_FIN) && !FLUSH;
            if (accept) begin
                op_q    <= SELECT[2:0];
                sign1_q <= s1;
                sign2_q <= s2;
                dz_q    <= dz;
                ovf_q   <= ovf;
                mag1_q  <= m1;
                acc_q   <= {{XLEN{1'b0}}, m2};
                cnt_q   <= '0;
            end else if (state_q == MDU_MUL) begin
                acc_q   <= acc_next;
                cnt_q   <= cnt_q + CW'(1);
            end
            if (state_q == MDU_FIN && !FLUSH) begin
                result_q <= fin_res;
            end
        end
    end

    assign BUSY   = (state_q != MDU_IDLE);
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [4:0]  SELECT;
    logic [31:0] DATA1, DATA2;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_res;

    always #5 CLK = ~CLK;

    muldiv_unit dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        ia = int'(a);
        ib = int'(b);
        case (sel)
            5'b01000: begin p = 64'(sa * sb); return p[31:0];  end
            5'b01001: begin p = 64'(sa * sb); return p[63:32]; end
            5'b01010: begin p = 64'(ua * ub); return p[63:32]; end
            5'b01011: begin p = 64'(sa * ub); return p[63:32]; end
            5'b01100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            5'b01101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            5'b01110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            5'b01111: return (b == 32'd0) ? a : a % b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        bit is_div = (sel >= 5'b01100);
        bit signed_div = (sel == 5'b01100) || (sel == 5'b01110);
        if (is_div && (b == 32'd0 || (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called one cycle after acceptance; returns the cycle index DONE was seen (0 = never)
    task automatic wait_done(input int c0, output int done_cyc, output int busy_cnt);
        done_cyc = 0;
        busy_cnt = 0;
        for (int c = c0; c <= 80; c++) begin
            if (DONE) begin
                done_cyc = c;
                break;
            end
            if (BUSY) busy_cnt++;
            tick();
        end
    endtask

    task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        START  = 1'b1;
        tick();
        START  = 1'b0;
        SELECT = 5'($urandom);
        DATA1  = $urandom;
        DATA2  = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          lat, done_cyc, busy_cnt;
        exp = model(sel, a, b);
        lat = model_lat(sel, a, b);
        issue(sel, a, b);
        wait_done(1, done_cyc, busy_cnt);
        chk({tag, ".result"}, RESULT, exp);
        chk({tag, ".done_cyc"}, 32'(done_cyc), 32'(lat));
        chk({tag, ".busy_cyc"}, 32'(busy_cnt), 32'(lat - 1));
        last_res = exp;
    endtask

    initial begin
        logic [4:0]  sel;
        logic [31:0] a, b;
        int          done_cyc, busy_cnt, pulses;

        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        SELECT = 5'd0; DATA1 = 32'd0; DATA2 = 32'd0;
        last_res = 32'd0;
        tick();
        tick();
        RESET = 1'b0;
        chk("reset.busy", {31'd0, BUSY}, 32'd0);
        chk("reset.done", {31'd0, DONE}, 32'd0);
        chk("reset.result", RESULT, 32'd0);

        run_op("mul_7_m3", 5'b01000, 32'd7, 32'hFFFF_FFFD);
        chk("mul_7_m3.const", RESULT, 32'hFFFF_FFEB);
        tick();
        chk("done_pulse_width", {31'd0, DONE}, 32'd0);

        run_op("mulh_ff", 5'b01001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        // next START is raised while DONE is high: back-to-back issue
        chk("b2b.done_high", {31'd0, DONE}, 32'd1);
        run_op("mulhu_ff", 5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_ff", 5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2", 5'b01100, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", 5'b01110, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_7_2", 5'b01101, 32'd7, 32'd2);
        run_op("remu_7_2", 5'b01111, 32'd7, 32'd2);
        run_op("divu_5_0", 5'b01101, 32'd5, 32'd0);
        run_op("rem_5_0", 5'b01110, 32'd5, 32'd0);
        run_op("div_ovf", 5'b01100, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 5'b01110, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_big_m1", 5'b01101, 32'h8000_0000, 32'hFFFF_FFFF);

        for (int i = 0; i < 40; i++) begin
            sel = 5'(8 + $urandom_range(7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(15)) - 32'd8;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op("rand", sel, a, b);
        end

        // START while busy must not disturb the running multiply
        issue(5'b01000, 32'd123456, 32'd789);
        repeat (4) tick();
        SELECT = 5'b01101; DATA1 = 32'd99; DATA2 = 32'd3; START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(6, done_cyc, busy_cnt);
        chk("start_busy.result", RESULT, model(5'b01000, 32'd123456, 32'd789));
        chk("start_busy.done_cyc", 32'(done_cyc), 32'd34);
        last_res = RESULT;
        tick();

        // FLUSH sampled at cycle 10 returns to IDLE at cycle 11
        issue(5'b01101, 32'hDEAD_BEEF, 32'd77);
        repeat (9) tick();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("flush.busy", {31'd0, BUSY}, 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (DONE) pulses++;
            tick();
        end
        chk("flush.no_done", 32'(pulses), 32'd0);
        chk("flush.result_held", RESULT, last_res);

        SELECT = 5'b00000; DATA1 = 32'd3; DATA2 = 32'd4; START = 1'b1;
        tick();
        START = 1'b0;
        chk("nonmop.busy", {31'd0, BUSY}, 32'd0);
        tick();
        chk("nonmop.done", {31'd0, DONE}, 32'd0);
        chk("nonmop.result", RESULT, last_res);

        SELECT = 5'b01000; DATA1 = 32'd3; DATA2 = 32'd4; START = 1'b1; FLUSH = 1'b1;
        tick();
        START = 1'b0; FLUSH = 1'b0;
        chk("flush_idle.busy", {31'd0, BUSY}, 32'd0);

        // RESET for two cycles in the middle of a divide
        issue(5'b01100, 32'hFFFF_0000, 32'd13);
        repeat (9) tick();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        chk("rst_mid.busy", {31'd0, BUSY}, 32'd0);
        chk("rst_mid.done", {31'd0, DONE}, 32'd0);
        chk("rst_mid.result", RESULT, 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (DONE) pulses++;
            tick();
        end
        chk("rst_mid.no_done", 32'(pulses), 32'd0);

        run_op("after_rst", 5'b01111, 32'd1000, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
